// File: rtl/password_enroll_writer.sv
// rtl/password_enroll_writer.sv - two-pass password entry, RAM commit and read-back verify
module password_enroll_writer #(
    parameter int DIGITS    = 4,
    parameter int DATA_W    = 4,
    parameter int ADDR_W    = 5,
    parameter int BASE_ADDR = 0,
    parameter int RD_LAT    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              Start_Enroll,
    input  logic              Digit_Enter,
    input  logic [DATA_W-1:0] Digit,
    output logic [ADDR_W-1:0] RAM_addr,
    output logic [DATA_W-1:0] RAM_data,
    output logic              RAM_wren,
    input  logic [DATA_W-1:0] q_RAM,
    output logic [1:0]        Digit_Idx,
    output logic              Busy,
    output logic              Done,
    output logic              Mismatch,
    output logic              Write_Fail
);

    localparam int         CNT_W    = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [1:0] LAST_IDX = 2'(DIGITS - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_ENTER1,
        S_ENTER2,
        S_WRITE,
        S_WR_NEXT,
        S_RD_ADDR,
        S_RD_WAIT,
        S_RD_CHECK,
        S_DONE,
        S_FAIL
    } state_t;

    state_t                         state_q, state_d;
    logic [1:0]                     idx_q, idx_d;
    logic                           btn_q;
    logic [DIGITS-1:0][DATA_W-1:0]  digit_buf_q, digit_buf_d;
    logic                           mm_q, mm_d;
    logic [CNT_W-1:0]               cnt_q, cnt_d;
    logic [ADDR_W-1:0]              ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0]              ram_data_q, ram_data_d;
    logic                           ram_wren_q, ram_wren_d;
    logic                           done_q, done_d;
    logic                           mismatch_q, mismatch_d;
    logic                           wfail_q, wfail_d;

    logic                           edge_det;
    logic                           mm_now;
    logic [ADDR_W-1:0]              cur_addr;

    assign edge_det = Digit_Enter & ~btn_q;
    assign cur_addr = ADDR_W'(BASE_ADDR) + ADDR_W'(idx_q);

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        digit_buf_d = digit_buf_q;
        mm_d        = mm_q;
        cnt_d       = cnt_q;
        ram_addr_d  = ram_addr_q;
        ram_data_d  = ram_data_q;
        ram_wren_d  = 1'b0;
        done_d      = done_q;
        mismatch_d  = mismatch_q;
        wfail_d     = wfail_q;
        mm_now      = mm_q | (Digit != digit_buf_q[idx_q]);

        case (state_q)
            S_IDLE, S_DONE, S_FAIL: begin
                if (Start_Enroll) begin
                    state_d    = S_ENTER1;
                    done_d     = 1'b0;
                    mismatch_d = 1'b0;
                    wfail_d    = 1'b0;
                    idx_d      = 2'd0;
                    mm_d       = 1'b0;
                end
            end
            S_ENTER1: begin
                if (edge_det) begin
                    digit_buf_d[idx_q] = Digit;
                    if (idx_q == LAST_IDX) begin
                        idx_d   = 2'd0;
                        state_d = S_ENTER2;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
            end
            S_ENTER2: begin
                if (edge_det) begin
                    mm_d = mm_now;
                    // The last digit's own comparison must count toward the verdict.
                    if (idx_q == LAST_IDX) begin
                        idx_d = 2'd0;
                        if (mm_now) begin
                            state_d    = S_FAIL;
                            mismatch_d = 1'b1;
                        end else begin
                            state_d = S_WRITE;
                        end
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
            end
            S_WRITE: begin
                ram_addr_d = cur_addr;
                ram_data_d = digit_buf_q[idx_q];
                ram_wren_d = 1'b1;
                state_d    = S_WR_NEXT;
            end
            S_WR_NEXT: begin
                if (idx_q == LAST_IDX) begin
                    idx_d   = 2'd0;
                    state_d = S_RD_ADDR;
                end else begin
                    idx_d   = idx_q + 2'd1;
                    state_d = S_WRITE;
                end
            end
            S_RD_ADDR: begin
                ram_addr_d = cur_addr;
                cnt_d      = '0;
                state_d    = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                // q_RAM reflects the new address once RD_LAT cycles have elapsed.
                if (cnt_q == CNT_W'(RD_LAT - 1)) begin
                    state_d = S_RD_CHECK;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RD_CHECK: begin
                if (q_RAM != digit_buf_q[idx_q]) begin
                    wfail_d = 1'b1;
                    state_d = S_FAIL;
                end else if (idx_q == LAST_IDX) begin
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + 2'd1;
                    state_d = S_RD_ADDR;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            idx_q      <= 2'd0;
            btn_q      <= 1'b0;
            mm_q       <= 1'b0;
            cnt_q      <= '0;
            ram_addr_q <= '0;
            ram_data_q <= '0;
            ram_wren_q <= 1'b0;
            done_q     <= 1'b0;
            mismatch_q <= 1'b0;
            wfail_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            btn_q      <= Digit_Enter;
            mm_q       <= mm_d;
            cnt_q      <= cnt_d;
            ram_addr_q <= ram_addr_d;
            ram_data_q <= ram_data_d;
            ram_wren_q <= ram_wren_d;
            done_q     <= done_d;
            mismatch_q <= mismatch_d;
            wfail_q    <= wfail_d;
        end
    end

    always_ff @(posedge clk) begin
        digit_buf_q <= digit_buf_d;
    end

    assign RAM_addr   = ram_addr_q;
    assign RAM_data   = ram_data_q;
    assign RAM_wren   = ram_wren_q;
    assign Done       = done_q;
    assign Mismatch   = mismatch_q;
    assign Write_Fail = wfail_q;
    assign Busy       = !(state_q == S_IDLE || state_q == S_DONE || state_q == S_FAIL);
    assign Digit_Idx  = (state_q == S_ENTER1 || state_q == S_ENTER2) ? idx_q : 2'd0;

endmodule

// File: tb/tb_password_enroll_writer.sv
// tb/tb_password_enroll_writer.sv - vector table plus RAM write scoreboard for password_enroll_writer
module tb_password_enroll_writer;

    logic       clk = 1'b0;
    logic       rst;
    logic       Start_Enroll;
    logic       Digit_Enter;
    logic [3:0] Digit;
    logic [4:0] RAM_addr;
    logic [3:0] RAM_data;
    logic       RAM_wren;
    logic [3:0] q_RAM;
    logic [1:0] Digit_Idx;
    logic       Busy, Done, Mismatch, Write_Fail;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    password_enroll_writer dut (
        .clk(clk), .rst(rst), .Start_Enroll(Start_Enroll), .Digit_Enter(Digit_Enter),
        .Digit(Digit), .RAM_addr(RAM_addr), .RAM_data(RAM_data), .RAM_wren(RAM_wren),
        .q_RAM(q_RAM), .Digit_Idx(Digit_Idx), .Busy(Busy), .Done(Done),
        .Mismatch(Mismatch), .Write_Fail(Write_Fail)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM model: two-stage read pipeline, optional stuck value at address 2
    logic [3:0] mem [32];
    logic [3:0] rd_p1;
    bit         corrupt_en = 1'b0;
    always @(posedge clk) begin
        if (RAM_wren) mem[RAM_addr] <= (corrupt_en && RAM_addr == 5'd2) ? 4'hF : RAM_data;
        rd_p1 <= mem[RAM_addr];
        q_RAM <= rd_p1;
    end

    typedef struct {
        logic [4:0] addr;
        logic [3:0] data;
        int         cyc;
    } wr_t;
    wr_t exp_q[$];

    typedef struct {
        logic [15:0] first;
        logic [15:0] second;
        bit          corrupt;
        bit          disturb;
        logic [2:0]  exp_flags;
        int          exp_lat;
    } vec_t;
    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [3:0] dig(input logic [15:0] w, input int i);
        return w[15-4*i -: 4];
    endfunction

    always @(negedge clk) begin
        wr_t w;
        if (RAM_wren) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_wren: got addr %0d data %0h, expected no write (cycle %0d)",
                         RAM_addr, RAM_data, cyc);
            end else begin
                w = exp_q.pop_front();
                chk("wren_addr", RAM_addr, w.addr);
                chk("wren_data", RAM_data, w.data);
                chk("wren_cycle", cyc, w.cyc);
            end
        end
    end

    task automatic enter_digit(input logic [3:0] d);
        @(negedge clk);
        Digit       = d;
        Digit_Enter = 1'b1;
        @(negedge clk);
        Digit_Enter = 1'b0;
        @(negedge clk);
    endtask

    task automatic start_enroll();
        @(negedge clk);
        Start_Enroll = 1'b1;
        @(negedge clk);
        Start_Enroll = 1'b0;
        chk("start_busy", Busy, 1);
        chk("start_idx", Digit_Idx, 0);
        chk("start_flags", {Done, Mismatch, Write_Fail}, 0);
    endtask

    // First entry plus the first DIGITS-1 confirm digits
    task automatic enter_all_but_last(input logic [15:0] first, input logic [15:0] second,
                                      input bit disturb);
        for (int i = 0; i < 4; i++) begin
            enter_digit(dig(first, i));
            chk("idx_enter1", Digit_Idx, (i + 1) % 4);
        end
        for (int i = 0; i < 3; i++) begin
            if (disturb && i == 1) begin
                @(negedge clk);
                Start_Enroll = 1'b1;
                @(negedge clk);
                Start_Enroll = 1'b0;
            end
            enter_digit(dig(second, i));
            chk("idx_enter2", Digit_Idx, i + 1);
            chk("mm_not_early", Mismatch, 0);
        end
    endtask

    task automatic run_vector(input vec_t v);
        int  c0;
        int  off;
        bit  got;
        corrupt_en = v.corrupt;
        start_enroll();
        enter_all_but_last(v.first, v.second, v.disturb);
        @(negedge clk);
        Digit       = dig(v.second, 3);
        Digit_Enter = 1'b1;
        c0          = cyc;
        if (v.first == v.second)
            for (int i = 0; i < 4; i++) exp_q.push_back('{5'(i), dig(v.first, i), c0 + 2 + 2 * i});
        got = 1'b0;
        off = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            off = cyc - c0;
            if (Done || Mismatch || Write_Fail) begin
                got = 1'b1;
                break;
            end
            Digit_Enter  = (v.disturb && off < 20) ? off[0] : 1'b0;
            Digit        = v.disturb ? 4'hE : Digit;
            Start_Enroll = v.disturb && off >= 1 && off <= 3;
        end
        Digit_Enter  = 1'b0;
        Start_Enroll = 1'b0;
        chk("completion_seen", got, 1);
        chk("latency", off, v.exp_lat);
        chk("flags", {Done, Mismatch, Write_Fail}, v.exp_flags);
        chk("busy_after", Busy, 0);
        chk("idx_after", Digit_Idx, 0);
        if (v.exp_flags[2])
            for (int i = 0; i < 4; i++) chk("ram_content", mem[i], dig(v.first, i));
        if (v.exp_flags[0]) chk("no_read_past_fail", RAM_addr, 2);
        if (v.exp_flags[1]) begin
            repeat (6) @(negedge clk);
            chk("fail_held", {Busy, Mismatch}, 2'b01);
        end
        chk("queue_drained", exp_q.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int c0;
        vecs[0] = '{16'h3591, 16'h3591, 1'b0, 1'b0, 3'b100, 25};
        vecs[1] = '{16'h3591, 16'h3592, 1'b0, 1'b0, 3'b010, 1};
        vecs[2] = '{16'h3591, 16'h3591, 1'b1, 1'b0, 3'b001, 21};
        vecs[3] = '{16'h0000, 16'h0000, 1'b0, 1'b0, 3'b100, 25};
        vecs[4] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 3'b100, 25};
        vecs[5] = '{16'h1234, 16'h0234, 1'b0, 1'b0, 3'b010, 1};
        vecs[6] = '{16'h789A, 16'h789A, 1'b1, 1'b0, 3'b001, 21};
        vecs[7] = '{16'h2468, 16'h2468, 1'b0, 1'b1, 3'b100, 25};
        for (int i = 0; i < 32; i++) mem[i] = 4'h0;

        rst          = 1'b0;
        Start_Enroll = 1'b0;
        Digit_Enter  = 1'b1;
        Digit        = 4'h7;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {RAM_addr, RAM_data, RAM_wren, Digit_Idx, Busy, Done, Mismatch, Write_Fail}, 0);

        rst = 1'b1;
        @(negedge clk);
        Start_Enroll = 1'b1;
        @(negedge clk);
        Start_Enroll = 1'b0;
        chk("held_btn_busy", Busy, 1);
        repeat (3) @(negedge clk);
        Digit_Enter = 1'b0;
        @(negedge clk);
        chk("held_btn_no_digit", Digit_Idx, 0);
        enter_digit(4'h2);
        chk("first_real_digit", Digit_Idx, 1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        chk("reset_to_idle", {Busy, Digit_Idx}, 0);

        for (int i = 0; i < 8; i++) run_vector(vecs[i]);

        // Reset during WR_NEXT following the second write pulse
        corrupt_en = 1'b0;
        start_enroll();
        enter_all_but_last(16'h3591, 16'h3591, 1'b0);
        @(negedge clk);
        Digit       = 4'h1;
        Digit_Enter = 1'b1;
        c0          = cyc;
        exp_q.push_back('{5'd0, 4'h3, c0 + 2});
        exp_q.push_back('{5'd1, 4'h5, c0 + 4});
        @(negedge clk);
        Digit_Enter = 1'b0;
        repeat (3) @(negedge clk);
        chk("second_wren_high", {RAM_wren, RAM_addr}, {1'b1, 5'd1});
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        chk("midwrite_reset_outputs", {RAM_addr, RAM_data, RAM_wren, Digit_Idx, Busy, Done, Mismatch, Write_Fail}, 0);
        repeat (10) @(negedge clk);
        chk("midwrite_queue", exp_q.size(), 0);
        run_vector(vecs[0]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
